// File: rtl/pwm_capture.sv
// pwm_capture: three-channel PWM high-time / period measurement.
// Each channel synchronizes its input, detects edges and runs an
// IDLE/HIGH/LOW state machine that publishes high time and rise-to-rise
// period (saturating counters) with a one-cycle meas_valid pulse.
// Optional feature: define PWM_CAP_TIMEOUT_EN to add a per-channel
// no-edge timeout that raises stuck[i] and returns the channel to IDLE.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [2:0]         pwm_in,
  output logic [3*CNT_W-1:0] high_time,
  output logic [3*CNT_W-1:0] period,
  output logic [2:0]         meas_valid,
  output logic [2:0]         overflow,
  output logic [2:0]         stuck
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (2**CNT_W) - 1) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT_CYC out of range for CNT_W");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] high_arr   [3];
  logic [CNT_W-1:0] period_arr [3];
  logic             mv_arr     [3];
  logic             ovf_arr    [3];
  logic             stuck_arr  [3];

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic             sync_0, sync_1, prev;
    logic             rise, fall, tmo_hit;
    logic             restart, capture, publish;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] hi_cnt, per_cnt, hi_cap, hi_res, per_res;
    logic             mv_q, ovf_q, stuck_q;

    assign rise = sync_1 & ~prev;
    assign fall = ~sync_1 & prev;

    // Two-flop synchronizer plus one history flop for edge detection;
    // keeps sampling while capture is disabled.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the result is order-independent.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_0 <= 1'b0;
        sync_1 <= 1'b0;
        prev   <= 1'b0;
      end else begin
        sync_0 <= pwm_in[ch];
        sync_1 <= sync_0;
        prev   <= sync_1;
      end
    end

`ifdef PWM_CAP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] idle_cnt;

    // Fires on the TIMEOUT_CYC-th consecutive enabled cycle with no edge.
    assign tmo_hit = enable & ~(rise | fall) & (idle_cnt == TMO_M1);

    // No-edge counter and sticky stuck flag, cleared by any edge or disable.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        idle_cnt <= '0;
        stuck_q  <= 1'b0;
      end else if (!enable || rise || fall) begin
        idle_cnt <= '0;
        stuck_q  <= 1'b0;
      end else begin
        if (idle_cnt != TMO) idle_cnt <= idle_cnt + 1'b1;
        if (tmo_hit)         stuck_q  <= 1'b1;
      end
    end
`else
    assign tmo_hit = 1'b0;
    assign stuck_q = 1'b0;
`endif

    // Channel state register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
    end

    // Next-state and per-cycle strobes for the datapath.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
      state_nxt = state;
      restart   = 1'b0;
      capture   = 1'b0;
      publish   = 1'b0;
      if (!enable || tmo_hit) begin
        state_nxt = IDLE;
      end else begin
        unique case (state)
          IDLE: if (rise) begin
            state_nxt = HIGH;
            restart   = 1'b1;
          end
          HIGH: if (fall) begin
            state_nxt = LOW;
            capture   = 1'b1;
          end
          LOW: if (rise) begin
            state_nxt = HIGH;
            publish   = 1'b1;
            restart   = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    // Counters start at 1 on the rise cycle so H synchronized high cycles
    // read back as H; published fields hold between meas_valid pulses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hi_cnt  <= '0;
        per_cnt <= '0;
        hi_cap  <= '0;
        hi_res  <= '0;
        per_res <= '0;
        mv_q    <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (!enable) begin
        hi_cnt  <= '0;
        per_cnt <= '0;
        hi_cap  <= '0;
        mv_q    <= 1'b0;
      end else begin
        mv_q <= publish;
        if (publish) begin
          hi_res  <= hi_cap;
          per_res <= per_cnt;
          ovf_q   <= (hi_cap == CNT_MAX) || (per_cnt == CNT_MAX);
        end
        if (capture) hi_cap <= hi_cnt;
        if (restart) begin
          hi_cnt  <= CNT_W'(1);
          per_cnt <= CNT_W'(1);
        end else if (state != IDLE) begin
          per_cnt <= sat_inc(per_cnt);
          if (state == HIGH) hi_cnt <= sat_inc(hi_cnt);
        end
      end
    end

    assign high_arr[ch]   = hi_res;
    assign period_arr[ch] = per_res;
    assign mv_arr[ch]     = mv_q;
    assign ovf_arr[ch]    = ovf_q;
    assign stuck_arr[ch]  = stuck_q;
  end

  // Pack per-channel results onto the flat output buses.
  always_comb begin
    high_time  = '0;
    period     = '0;
    meas_valid = '0;
    overflow   = '0;
    stuck      = '0;
    for (int i = 0; i < 3; i++) begin
      high_time[i*CNT_W +: CNT_W] = high_arr[i];
      period[i*CNT_W +: CNT_W]    = period_arr[i];
      meas_valid[i]               = mv_arr[i];
      overflow[i]                 = ovf_arr[i];
      stuck[i]                    = stuck_arr[i];
    end
  end

endmodule
